booth_adder_subtractor: RTL and testbench
=========================================

# booth_adder_subtractor

Registered add/subtract stage for the Booth radix-2 multiplier datapath. Each cycle it takes the accumulator `A`, the multiplicand `M` and the Booth bit pair `{Q0, Q-1}`, then produces `A`, `A+M` or `A-M` one clock later with a signed-overflow flag. The multiplier control FSM calls it once per Booth iteration, before the arithmetic right shift of `{A, Q, Q-1}`.

## Interface
- Clocking: one clock; reset is asynchronous and active-high.
- Parameters: none. Data width is fixed at 32 bits.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous active-high reset.
- `in_valid`  input  1  operands valid this cycle; capture on the next rising edge.
- `A`  input  32  accumulator (partial product, upper half), two's complement.
- `M`  input  32  multiplicand, two's complement.
- `BoothOp`  input  2  Booth pair `{Q0, Q-1}`.
- `result`  output  32  registered accumulator update.
- `overflow`  output  1  registered signed overflow of the selected operation.
- `out_valid`  output  1  `result` and `overflow` hold a new value this cycle.

## Operation
`BoothOp` decode:
- `2'b00`: result = A (no operation).
- `2'b01`: result = A + M.
- `2'b10`: result = A − M, computed as A + ~M + 1 (a single 32-bit adder with carry-in 1 and M inverted).
- `2'b11`: result = A (no operation).

Arithmetic rules:
- All arithmetic is modulo 2^32; the carry-out is discarded.
- Add overflow = (A[31] == M[31]) && (sum[31] != A[31]).
- Subtract overflow = (A[31] != M[31]) && (diff[31] != A[31]). This includes M = 0x80000000.
- For `00` and `11`, overflow = 0.
- The combinational adder/subtractor and the decode feed the output registers directly. No other state is kept.

## Timing
- Latency is exactly 1 clock: inputs sampled at edge N appear on the outputs after edge N.
- On a rising edge with `in_valid`=1:
  - `result` and `overflow` load the computed values.
  - `out_valid` is set to 1.
- On a rising edge with `in_valid`=0:
  - `result` and `overflow` hold their previous values.
  - `out_valid` is set to 0.
- Back-to-back `in_valid` is supported. Full throughput is one operation per cycle, with no bubbles and no backpressure.
- Reset:
  - While `rst` is high: `result`=0, `overflow`=0, `out_valid`=0. This applies immediately, without waiting for a clock edge.
  - Reset asserted mid-stream discards any captured operation.
  - The first capture after reset deassertion occurs at the first rising edge where `rst`=0 and `in_valid`=1.
- Changes to `BoothOp`, `A` or `M` between edges have no effect on the outputs until they are sampled.

## Test plan
- A=5, M=2, `in_valid`=1, `BoothOp` stepped one per cycle through 0, 1, 2, 3 -> `result` one cycle later is 5, 7, 3, 5 respectively; `overflow`=0 throughout; `out_valid`=1 on each of the four cycles.
- A=0x7FFFFFFF, M=1, op `01` -> `result`=0x80000000, `overflow`=1. Then A=0x80000000, M=1, op `10` -> `result`=0x7FFFFFFF, `overflow`=1.
- Signed operands:
  - A=0xFFFFFFFD (−3), M=4, op `10` -> `result`=0xFFFFFFF9 (−7), `overflow`=0.
  - Same operands, op `01` -> `result`=1, `overflow`=0.
- A=0, M=0x80000000, op `10` -> `result`=0x80000000, `overflow`=1. Op `11` with the same operands -> `result`=0, `overflow`=0.
- Capture A=5, M=2, op `01` (`result`=7), then hold `in_valid`=0 for 3 cycles while changing A, M and `BoothOp` -> `result` stays 7; `out_valid` drops to 0 after the first idle edge.
- With `result`=7 and `out_valid`=1, assert `rst` between clock edges -> all outputs go to 0 immediately without a clock edge. Deassert `rst`, then apply A=5, M=2, op `10` -> `result`=3 one cycle later.

Source files
------------

// File: rtl/booth_adder_subtractor.sv
// Booth radix-2 add/subtract stage: A, A+M or A-M chosen by {Q0,Q-1}, with signed overflow.
// One-cycle registered latency, accepts an operation every cycle, no backpressure.
module booth_adder_subtractor (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] A,
  input  logic [31:0] M,
  input  logic [1:0]  BoothOp,
  output logic [31:0] result,
  output logic        overflow,
  output logic        out_valid
);

  logic        is_add;
  logic        is_sub;
  logic [31:0] addend;
  logic [31:0] sum;
  logic        sum_ovf;

  logic [31:0] result_d, result_q;
  logic        overflow_d, overflow_q;
  logic        out_valid_q;

  // Subtraction reuses the single adder: A + ~M + 1.
  assign is_add = (BoothOp == 2'b01);
  assign is_sub = (BoothOp == 2'b10);
  assign addend = is_sub ? ~M : M;
  assign sum    = A + addend + {31'd0, is_sub};

  // With the inverted addend, the add rule also covers subtraction (incl. M = 0x80000000).
  assign sum_ovf = (A[31] == addend[31]) && (sum[31] != A[31]);

  always_comb begin
    result_d   = A;
    overflow_d = 1'b0;
    if (is_add || is_sub) begin
      result_d   = sum;
      overflow_d = sum_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= 32'd0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q   <= result_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign result    = result_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_booth_adder_subtractor.sv
// Directed self-checking bench for booth_adder_subtractor.
module tb_booth_adder_subtractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] M;
  logic [1:0]  BoothOp;
  logic [31:0] result;
  logic        overflow;
  logic        out_valid;

  int total;
  int bad;

  booth_adder_subtractor dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (A),
    .M        (M),
    .BoothOp  (BoothOp),
    .result   (result),
    .overflow (overflow),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [31:0] exp_r,
                           input logic exp_o, input logic exp_v);
    total++;
    assert (result === exp_r) else begin
      bad++;
      $error("FAIL %s result: got %h want %h", tag, result, exp_r);
    end
    total++;
    assert (overflow === exp_o) else begin
      bad++;
      $error("FAIL %s overflow: got %b want %b", tag, overflow, exp_o);
    end
    total++;
    assert (out_valid === exp_v) else begin
      bad++;
      $error("FAIL %s out_valid: got %b want %b", tag, out_valid, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] m,
                       input logic [1:0] op);
    in_valid = v;
    A        = a;
    M        = m;
    BoothOp  = op;
  endtask

  // Wait for the next rising edge, then sample just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 2'b00);
    #1 rst = 1'b1;
    #1 check_out("reset_async", 32'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd5, 32'd2, 2'b01);
    tick();
    check_out("reset_held_with_valid", 32'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;

    // Op sweep 0..3 on A=5, M=2
    drive(1'b1, 32'd5, 32'd2, 2'b00);
    tick(); check_out("op00", 32'd5, 1'b0, 1'b1);
    drive(1'b1, 32'd5, 32'd2, 2'b01);
    tick(); check_out("op01", 32'd7, 1'b0, 1'b1);
    drive(1'b1, 32'd5, 32'd2, 2'b10);
    tick(); check_out("op10", 32'd3, 1'b0, 1'b1);
    drive(1'b1, 32'd5, 32'd2, 2'b11);
    tick(); check_out("op11", 32'd5, 1'b0, 1'b1);

    // Overflow boundaries
    drive(1'b1, 32'h7FFF_FFFF, 32'd1, 2'b01);
    tick(); check_out("add_ovf", 32'h8000_0000, 1'b1, 1'b1);
    drive(1'b1, 32'h8000_0000, 32'd1, 2'b10);
    tick(); check_out("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Signed operands
    drive(1'b1, 32'hFFFF_FFFD, 32'd4, 2'b10);
    tick(); check_out("neg_sub", 32'hFFFF_FFF9, 1'b0, 1'b1);
    drive(1'b1, 32'hFFFF_FFFD, 32'd4, 2'b01);
    tick(); check_out("neg_add", 32'd1, 1'b0, 1'b1);

    // Subtracting the most negative value
    drive(1'b1, 32'd0, 32'h8000_0000, 2'b10);
    tick(); check_out("sub_minint", 32'h8000_0000, 1'b1, 1'b1);
    drive(1'b1, 32'd0, 32'h8000_0000, 2'b11);
    tick(); check_out("nop_minint", 32'd0, 1'b0, 1'b1);

    // Hold while idle, inputs wandering
    drive(1'b1, 32'd5, 32'd2, 2'b01);
    tick(); check_out("hold_capture", 32'd7, 1'b0, 1'b1);
    drive(1'b0, 32'h7FFF_FFFF, 32'd1, 2'b01);
    #2 check_out("between_edges", 32'd7, 1'b0, 1'b1);
    tick(); check_out("idle1", 32'd7, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 32'h8000_0000, 2'b10);
    tick(); check_out("idle2", 32'd7, 1'b0, 1'b0);
    drive(1'b0, 32'd9, 32'd9, 2'b11);
    tick(); check_out("idle3", 32'd7, 1'b0, 1'b0);

    // Mid-stream async reset
    drive(1'b1, 32'd5, 32'd2, 2'b01);
    tick(); check_out("pre_reset", 32'd7, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 check_out("reset_midstream", 32'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    drive(1'b1, 32'd5, 32'd2, 2'b10);
    tick(); check_out("post_reset", 32'd3, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
